// File: rtl/timer_irq_source.sv
// timer_irq_source
//   Memory-mapped machine timer that feeds the core's CSR trap logic. It sits on
//   the data-memory bus, keeps a free-running 64-bit mtime (with a prescaler),
//   compares it against a 64-bit mtimecmp and raises a level interrupt that holds
//   until the core acknowledges trap entry.
//
//   Register window (32 bytes at BASE_ADDR, addr[4:2] selects):
//     0x00 MTIME_LO  0x04 MTIME_HI  0x08 CMP_LO  0x0C CMP_HI
//     0x10 CTRL {AUTO,EN}  0x14 STATUS {PEND} (W1C)  0x18 PRESC  0x1C reads 0
//
// Ports
//   clk        clock
//   reset      synchronous, active-high reset
//   i_cs       bus select, same cycle as address/write
//   i_wr       1 = write, 0 = read
//   i_addr     byte address (addr[1:0] ignored)
//   i_mask     byte-lane write enables
//   i_wdata    write data
//   o_rdata    combinational read data (0 unless a read hits the window)
//   o_hit      i_cs && address inside the window
//   o_irq      registered timer interrupt request
//   i_irq_ack  one-cycle pulse: core has taken the timer trap
module timer_irq_source #(
    parameter logic [31:0] BASE_ADDR  = 32'h0000_0400,
    parameter int          PRESCALE_W = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_cs,
    input  logic        i_wr,
    input  logic [31:0] i_addr,
    input  logic [3:0]  i_mask,
    input  logic [31:0] i_wdata,
    output logic [31:0] o_rdata,
    output logic        o_hit,
    output logic        o_irq,
    input  logic        i_irq_ack
);

    typedef enum logic [1:0] {ST_OFF, ST_ARMED, ST_FIRE, ST_WAIT} state_t;

    state_t                  r_state, w_state_nxt;
    logic [63:0]             r_mtime, w_mtime_nxt;
    logic [63:0]             r_cmp, w_cmp_nxt, w_cmp_wrval;
    logic [63:0]             r_delta;
    logic [PRESCALE_W-1:0]   r_presc, w_presc_wrval;
    logic [PRESCALE_W-1:0]   r_cnt;
    logic                    r_en, r_auto, r_pend, r_irq;

    logic [2:0] w_sel;
    logic       w_we;
    logic       w_wr_mlo, w_wr_mhi, w_wr_clo, w_wr_chi;
    logic       w_wr_ctrl, w_wr_stat, w_wr_presc;
    logic       w_cmp_wr, w_mtime_wr;
    logic       w_en_set, w_en_clr, w_pend_w1c;
    logic       w_tick, w_match;
    logic       w_pend_set, w_pend_clr, w_auto_reload;
    logic       w_unused_addr;

    function automatic logic [31:0] f_merge(input logic [31:0] old,
                                            input logic [31:0] wd,
                                            input logic [3:0]  m);
        logic [31:0] res;
        for (int i = 0; i < 4; i++)
            res[8*i +: 8] = m[i] ? wd[8*i +: 8] : old[8*i +: 8];
        return res;
    endfunction

    // ---------------- bus decode ----------------
    assign w_unused_addr = ^i_addr[1:0];
    assign w_sel = i_addr[4:2];
    assign o_hit = i_cs && (i_addr[31:5] == BASE_ADDR[31:5]);
    // A write with no lanes enabled has no side effects at all.
    assign w_we  = o_hit && i_wr && (|i_mask);

    assign w_wr_mlo   = w_we && (w_sel == 3'd0);
    assign w_wr_mhi   = w_we && (w_sel == 3'd1);
    assign w_wr_clo   = w_we && (w_sel == 3'd2);
    assign w_wr_chi   = w_we && (w_sel == 3'd3);
    assign w_wr_ctrl  = w_we && (w_sel == 3'd4);
    assign w_wr_stat  = w_we && (w_sel == 3'd5);
    assign w_wr_presc = w_we && (w_sel == 3'd6);

    assign w_cmp_wr   = w_wr_clo || w_wr_chi;
    assign w_mtime_wr = w_wr_mlo || w_wr_mhi;
    assign w_en_set   = w_wr_ctrl && i_mask[0] &&  i_wdata[0];
    assign w_en_clr   = w_wr_ctrl && i_mask[0] && !i_wdata[0];
    assign w_pend_w1c = w_wr_stat && i_mask[0] &&  i_wdata[0];

    assign w_cmp_wrval = {w_wr_chi ? f_merge(r_cmp[63:32], i_wdata, i_mask) : r_cmp[63:32],
                          w_wr_clo ? f_merge(r_cmp[31:0],  i_wdata, i_mask) : r_cmp[31:0]};

    always_comb begin
        w_presc_wrval = r_presc;
        for (int b = 0; b < PRESCALE_W; b++)
            if (i_mask[b/8]) w_presc_wrval[b] = i_wdata[b];
    end

    // ---------------- timebase ----------------
    assign w_tick  = r_en && (r_cnt == r_presc);
    assign w_match = r_en && (r_mtime >= r_cmp);

    // A bus write to either mtime half replaces the increment for that cycle.
    always_comb begin
        w_mtime_nxt = r_mtime;
        if (w_mtime_wr) begin
            if (w_wr_mlo) w_mtime_nxt[31:0]  = f_merge(r_mtime[31:0],  i_wdata, i_mask);
            if (w_wr_mhi) w_mtime_nxt[63:32] = f_merge(r_mtime[63:32], i_wdata, i_mask);
        end else if (w_tick) begin
            w_mtime_nxt = r_mtime + 64'd1;
        end
    end

    // ---------------- FSM ----------------
    always_comb begin
        w_state_nxt   = r_state;
        w_pend_set    = 1'b0;
        w_pend_clr    = 1'b0;
        w_auto_reload = 1'b0;
        case (r_state)
            ST_OFF:   if (w_en_set) w_state_nxt = ST_ARMED;
            // A compare write in the same cycle defers the decision to the new value.
            ST_ARMED: if (w_match && !w_cmp_wr) begin
                          w_state_nxt = ST_FIRE;
                          w_pend_set  = 1'b1;
                      end
            // Only the ack leaves FIRE; a concurrent compare write beats AUTO reload.
            ST_FIRE:  if (i_irq_ack) begin
                          if (w_cmp_wr) begin
                              w_state_nxt = ST_ARMED;
                              w_pend_clr  = 1'b1;
                          end else if (r_auto) begin
                              w_state_nxt   = ST_ARMED;
                              w_pend_clr    = 1'b1;
                              w_auto_reload = 1'b1;
                          end else begin
                              w_state_nxt = ST_WAIT;
                          end
                      end
            ST_WAIT:  if (w_cmp_wr || w_pend_w1c) begin
                          w_state_nxt = ST_ARMED;
                          w_pend_clr  = 1'b1;
                      end
            default:  w_state_nxt = ST_OFF;
        endcase
        // Disabling overrides everything and leaves PEND as it was.
        if (w_en_clr) begin
            w_state_nxt   = ST_OFF;
            w_pend_set    = 1'b0;
            w_pend_clr    = 1'b0;
            w_auto_reload = 1'b0;
        end
    end

    always_comb begin
        w_cmp_nxt = r_cmp;
        if (w_cmp_wr)           w_cmp_nxt = w_cmp_wrval;
        else if (w_auto_reload) w_cmp_nxt = r_cmp + r_delta;
    end

    // ---------------- state registers ----------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_OFF;
            r_mtime <= '0;
            r_cmp   <= '1;
            r_delta <= '0;
            r_presc <= '0;
            r_cnt   <= '0;
            r_en    <= 1'b0;
            r_auto  <= 1'b0;
            r_pend  <= 1'b0;
            r_irq   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_mtime <= w_mtime_nxt;
            r_cmp   <= w_cmp_nxt;
            if (w_cmp_wr) r_delta <= w_cmp_wrval;

            if (w_wr_presc) r_presc <= w_presc_wrval;
            if (w_wr_presc)  r_cnt <= '0;
            else if (r_en)   r_cnt <= w_tick ? '0 : r_cnt + 1'b1;

            if (w_wr_ctrl && i_mask[0]) begin
                r_en   <= i_wdata[0];
                r_auto <= i_wdata[1];
            end

            if (w_pend_set)                    r_pend <= 1'b1;
            else if (w_pend_clr || w_pend_w1c) r_pend <= 1'b0;

            // High only while FIRE is both current and next: one cycle of
            // latency on entry, drops right at the exit edge.
            r_irq <= (r_state == ST_FIRE) && (w_state_nxt == ST_FIRE);
        end
    end

    assign o_irq = r_irq;

    // ---------------- read mux ----------------
    always_comb begin
        o_rdata = '0;
        if (o_hit && !i_wr) begin
            case (w_sel)
                3'd0: o_rdata = r_mtime[31:0];
                3'd1: o_rdata = r_mtime[63:32];
                3'd2: o_rdata = r_cmp[31:0];
                3'd3: o_rdata = r_cmp[63:32];
                3'd4: o_rdata = {30'd0, r_auto, r_en};
                3'd5: o_rdata = {31'd0, r_pend};
                3'd6: o_rdata[PRESCALE_W-1:0] = r_presc;
                default: o_rdata = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_timer_irq_source.sv
module tb_timer_irq_source;
    localparam logic [31:0] B = 32'h0000_0400;
    localparam logic [31:0] A_MLO = B + 32'h00, A_MHI = B + 32'h04, A_CLO = B + 32'h08,
                            A_CHI = B + 32'h0C, A_CTL = B + 32'h10, A_STA = B + 32'h14,
                            A_PRE = B + 32'h18;

    logic        clk = 1'b0;
    logic        reset;
    logic        i_cs, i_wr, i_irq_ack;
    logic [31:0] i_addr, i_wdata;
    logic [3:0]  i_mask;
    logic [31:0] o_rdata;
    logic        o_hit, o_irq;

    timer_irq_source dut (
        .clk(clk), .reset(reset), .i_cs(i_cs), .i_wr(i_wr), .i_addr(i_addr),
        .i_mask(i_mask), .i_wdata(i_wdata), .o_rdata(o_rdata), .o_hit(o_hit),
        .o_irq(o_irq), .i_irq_ack(i_irq_ack)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct packed {
        logic        wr;
        logic [31:0] addr;
        logic [3:0]  mask;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_hit;
    } vec_t;
    vec_t tbl[$];

    task automatic add(input logic wr, input logic [31:0] a, input logic [3:0] m,
                       input logic [31:0] d, input logic [31:0] er, input logic eh);
        vec_t v;
        v.wr = wr; v.addr = a; v.mask = m; v.wdata = d; v.exp_rdata = er; v.exp_hit = eh;
        tbl.push_back(v);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic wr_reg(input logic [31:0] a, input logic [3:0] m, input logic [31:0] d);
        i_cs = 1'b1; i_wr = 1'b1; i_addr = a; i_mask = m; i_wdata = d;
        @(posedge clk); #1;
        i_cs = 1'b0; i_wr = 1'b0; i_mask = 4'h0;
    endtask

    task automatic rd_chk(input string name, input logic [31:0] a, input logic [31:0] exp);
        i_cs = 1'b1; i_wr = 1'b0; i_addr = a;
        #1;
        check(name, o_rdata, exp);
        i_cs = 1'b0;
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic ack_pulse();
        i_irq_ack = 1'b1;
        tick(1);
        i_irq_ack = 1'b0;
    endtask

    initial begin
        reset = 1'b1; i_cs = 1'b0; i_wr = 1'b0; i_irq_ack = 1'b0;
        i_addr = '0; i_mask = '0; i_wdata = '0;
        tick(2);
        reset = 1'b0;

        // reset values, window decode, lane masks, reserved/unused bits
        add(0, A_MLO, 4'h0, 32'h0, 32'h0000_0000, 1);
        add(0, A_MHI, 4'h0, 32'h0, 32'h0000_0000, 1);
        add(0, A_CLO, 4'h0, 32'h0, 32'hFFFF_FFFF, 1);
        add(0, A_CHI, 4'h0, 32'h0, 32'hFFFF_FFFF, 1);
        add(0, A_CTL, 4'h0, 32'h0, 32'h0000_0000, 1);
        add(0, A_STA, 4'h0, 32'h0, 32'h0000_0000, 1);
        add(0, A_PRE, 4'h0, 32'h0, 32'h0000_0000, 1);
        add(0, B + 32'h1C, 4'h0, 32'h0, 32'h0000_0000, 1);
        add(0, B + 32'h20, 4'h0, 32'h0, 32'h0000_0000, 0);
        add(1, A_CLO, 4'b0001, 32'h1234_5678, 32'h0, 1);
        add(0, A_CLO, 4'h0, 32'h0, 32'hFFFF_FF78, 1);
        add(1, A_CLO, 4'b0000, 32'h0, 32'h0, 1);
        add(0, A_CLO, 4'h0, 32'h0, 32'hFFFF_FF78, 1);
        add(1, 32'h0000_0808, 4'hF, 32'h0, 32'h0, 0);
        add(0, A_CLO, 4'h0, 32'h0, 32'hFFFF_FF78, 1);
        add(1, A_CHI, 4'b1100, 32'hAABB_0000, 32'h0, 1);
        add(0, B + 32'h0E, 4'h0, 32'h0, 32'hAABB_FFFF, 1);
        add(1, B + 32'h1C, 4'hF, 32'hDEAD_BEEF, 32'h0, 1);
        add(0, B + 32'h1C, 4'h0, 32'h0, 32'h0000_0000, 1);
        add(1, A_PRE, 4'hF, 32'hFFFF_ABCD, 32'h0, 1);
        add(0, A_PRE, 4'h0, 32'h0, 32'h0000_ABCD, 1);
        add(1, A_CTL, 4'hF, 32'hFFFF_FFFC, 32'h0, 1);
        add(0, A_CTL, 4'h0, 32'h0, 32'h0000_0000, 1);

        check("rst_irq", {31'd0, o_irq}, 32'd0);
        for (int i = 0; i < tbl.size(); i++) begin
            i_cs = 1'b1; i_wr = tbl[i].wr; i_addr = tbl[i].addr;
            i_mask = tbl[i].mask; i_wdata = tbl[i].wdata;
            #1;
            check($sformatf("vec%0d_rdata", i), o_rdata, tbl[i].exp_rdata);
            check($sformatf("vec%0d_hit", i), {31'd0, o_hit}, {31'd0, tbl[i].exp_hit});
            tick(1);
            i_cs = 1'b0; i_wr = 1'b0; i_mask = 4'h0;
        end
        rd_chk("mtime_frozen_en0", A_MLO, 32'd0);

        // basic compare/fire/ack/W1C
        wr_reg(A_PRE, 4'hF, 32'd0);
        wr_reg(A_CHI, 4'hF, 32'd0);
        wr_reg(A_CLO, 4'hF, 32'd10);
        wr_reg(A_CTL, 4'hF, 32'd1);
        tick(10);
        rd_chk("t2_mtime10", A_MLO, 32'd10);
        check("t2_irq_lo_at10", {31'd0, o_irq}, 32'd0);
        tick(1);
        check("t2_irq_lo_fire", {31'd0, o_irq}, 32'd0);
        rd_chk("t2_pend_fire", A_STA, 32'd1);
        tick(1);
        check("t2_irq_rise", {31'd0, o_irq}, 32'd1);
        tick(5);
        check("t2_irq_hold", {31'd0, o_irq}, 32'd1);
        ack_pulse();
        check("t2_irq_ack", {31'd0, o_irq}, 32'd0);
        rd_chk("t2_pend_wait", A_STA, 32'd1);
        tick(3);
        check("t2_irq_wait", {31'd0, o_irq}, 32'd0);
        wr_reg(A_STA, 4'h1, 32'd1);
        rd_chk("t2_pend_w1c", A_STA, 32'd0);
        tick(1);
        rd_chk("t2_refire_pend", A_STA, 32'd1);
        check("t2_refire_irq0", {31'd0, o_irq}, 32'd0);
        tick(1);
        check("t2_refire_irq1", {31'd0, o_irq}, 32'd1);
        wr_reg(A_CTL, 4'hF, 32'd0);
        check("t2_disable_irq", {31'd0, o_irq}, 32'd0);
        rd_chk("t2_disable_pend", A_STA, 32'd1);
        wr_reg(A_STA, 4'h1, 32'd1);
        rd_chk("t2_pend_clr", A_STA, 32'd0);

        // 32-bit carry and 64-bit wrap, bus write beats tick
        wr_reg(A_MLO, 4'hF, 32'hFFFF_FFFE);
        wr_reg(A_MHI, 4'hF, 32'd0);
        wr_reg(A_CHI, 4'hF, 32'hFFFF_FFFF);
        wr_reg(A_CLO, 4'hF, 32'hFFFF_FFFF);
        wr_reg(A_CTL, 4'hF, 32'd1);
        tick(2);
        rd_chk("t3_carry_lo", A_MLO, 32'd0);
        rd_chk("t3_carry_hi", A_MHI, 32'd1);
        wr_reg(A_MHI, 4'hF, 32'hFFFF_FFFF);
        rd_chk("t3_lo_no_inc", A_MLO, 32'd0);
        wr_reg(A_MLO, 4'hF, 32'hFFFF_FFFF);
        rd_chk("t3_max_lo", A_MLO, 32'hFFFF_FFFF);
        rd_chk("t3_max_hi", A_MHI, 32'hFFFF_FFFF);
        tick(1);
        rd_chk("t3_wrap_lo", A_MLO, 32'd0);
        rd_chk("t3_wrap_hi", A_MHI, 32'd0);

        // prescaler
        wr_reg(A_CTL, 4'hF, 32'd0);
        wr_reg(A_STA, 4'h1, 32'd1);
        wr_reg(A_MLO, 4'hF, 32'd0);
        wr_reg(A_MHI, 4'hF, 32'd0);
        wr_reg(A_PRE, 4'hF, 32'd3);
        wr_reg(A_CTL, 4'hF, 32'd1);
        tick(3);
        rd_chk("t4_presc_c3", A_MLO, 32'd0);
        tick(1);
        rd_chk("t4_presc_c4", A_MLO, 32'd1);
        tick(3);
        rd_chk("t4_presc_c7", A_MLO, 32'd1);
        tick(1);
        rd_chk("t4_presc_c8", A_MLO, 32'd2);
        wr_reg(A_PRE, 4'hF, 32'd3);
        tick(3);
        rd_chk("t4_presc_clr_a", A_MLO, 32'd2);
        tick(1);
        rd_chk("t4_presc_clr_b", A_MLO, 32'd3);

        // ack and compare write in the same cycle; PEND W1C while firing
        wr_reg(A_CTL, 4'hF, 32'd0);
        wr_reg(A_STA, 4'h1, 32'd1);
        wr_reg(A_PRE, 4'hF, 32'd0);
        wr_reg(A_MLO, 4'hF, 32'd0);
        wr_reg(A_MHI, 4'hF, 32'd0);
        wr_reg(A_CHI, 4'hF, 32'd0);
        wr_reg(A_CLO, 4'hF, 32'd5);
        wr_reg(A_CTL, 4'hF, 32'd1);
        tick(7);
        check("t5_irq_fire", {31'd0, o_irq}, 32'd1);
        i_irq_ack = 1'b1;
        wr_reg(A_CLO, 4'hF, 32'd100);
        i_irq_ack = 1'b0;
        check("t5_irq_dropped", {31'd0, o_irq}, 32'd0);
        rd_chk("t5_pend_clr", A_STA, 32'd0);
        rd_chk("t5_cmp_written", A_CLO, 32'd100);
        tick(92);
        rd_chk("t5_mtime100", A_MLO, 32'd100);
        check("t5_irq_pre0", {31'd0, o_irq}, 32'd0);
        tick(1);
        check("t5_irq_pre1", {31'd0, o_irq}, 32'd0);
        tick(1);
        check("t5_refire", {31'd0, o_irq}, 32'd1);
        wr_reg(A_STA, 4'h1, 32'd1);
        rd_chk("t5_w1c_in_fire", A_STA, 32'd0);
        tick(3);
        check("t5_irq_holds", {31'd0, o_irq}, 32'd1);
        ack_pulse();
        check("t5_irq_ack", {31'd0, o_irq}, 32'd0);

        // AUTO reload, then reset while firing
        wr_reg(A_CTL, 4'hF, 32'd0);
        wr_reg(A_STA, 4'h1, 32'd1);
        wr_reg(A_MLO, 4'hF, 32'd0);
        wr_reg(A_MHI, 4'hF, 32'd0);
        wr_reg(A_CHI, 4'hF, 32'd0);
        wr_reg(A_CLO, 4'hF, 32'd50);
        wr_reg(A_CTL, 4'hF, 32'd3);
        tick(51);
        check("t6_irq_pre", {31'd0, o_irq}, 32'd0);
        tick(1);
        check("t6_irq_rise", {31'd0, o_irq}, 32'd1);
        ack_pulse();
        check("t6_irq_ack", {31'd0, o_irq}, 32'd0);
        rd_chk("t6_cmp_lo", A_CLO, 32'd100);
        rd_chk("t6_cmp_hi", A_CHI, 32'd0);
        rd_chk("t6_pend", A_STA, 32'd0);
        rd_chk("t6_ctrl", A_CTL, 32'd3);
        tick(48);
        check("t6_auto_pre", {31'd0, o_irq}, 32'd0);
        tick(1);
        check("t6_auto_fire", {31'd0, o_irq}, 32'd1);
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        check("t6_rst_irq", {31'd0, o_irq}, 32'd0);
        rd_chk("t6_rst_ctrl", A_CTL, 32'd0);
        rd_chk("t6_rst_pend", A_STA, 32'd0);
        rd_chk("t6_rst_cmp", A_CLO, 32'hFFFF_FFFF);
        rd_chk("t6_rst_mtime", A_MLO, 32'd0);
        tick(3);
        rd_chk("t6_rst_frozen", A_MLO, 32'd0);
        check("t6_rst_irq_stays", {31'd0, o_irq}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
